serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses one full-subtractor cell and a borrow flip-flop.
- Inverse-direction companion to the team's ripple full-adder datapath, used where area matters more than latency.
- Start/busy/done handshake; result and final borrow held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; one clock domain only.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while the shift operation is in progress.
- done  output  1  one-cycle pulse; diff/borrow valid from this cycle.
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 exactly when a < b (unsigned).

Behaviour:
- Reset: on rst high, asynchronously and immediately:
  - state=IDLE; busy=0, done=0, diff=0, borrow=0.
  - internal shift registers, bit counter and borrow FF cleared.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - FINISH: busy=0, done=1.
- Transitions:
  - IDLE -> SHIFT on start=1. Same edge: sa<=a, sb<=b, bff<=0, cnt<=0.
  - SHIFT stays for exactly WIDTH cycles. Each cycle:
    - d = sa[0]^sb[0]^bff
    - bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bff)
    - sa, sb shift right by one.
    - d shifts into MSB of the internal result register sr (shift right).
    - bff<=bo; cnt<=cnt+1.
  - When cnt = WIDTH-1 the next state is FINISH. The same edge loads diff<=final sr value including this cycle's d, and borrow<=bo.
  - FINISH -> IDLE after one cycle. If start=1 in FINISH it is accepted as in IDLE and the next state is SHIFT.
- Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles from start to done.
- Throughput: one operation per WIDTH+1 cycles, back-to-back via start during FINISH.
- start while busy=1: ignored; no re-capture of a/b, no effect on the current operation.
- diff and borrow change only on the FINISH-entry edge or on reset. During SHIFT they hold the previous result.
- a/b changes after capture: no effect on the current operation.
- Reset mid-SHIFT: operation abandoned, all outputs zero, no done pulse; the next start begins a fresh operation.
- Counter width: clog2(WIDTH)+1 bits, no wrap within an operation.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Two's-complement interpretation of diff is valid; signed overflow is not flagged.

Decomposition:
- Shared include file holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FINISH=2'd2, as localparams/defines.
  - default WIDTH.
- One sub-module: full_subtractor (x, y, bin -> d, bout), purely combinational.
  - Built from two half_subtractor instances plus an OR on the borrows, mirroring the adder structure.
  - Instantiated once inside serial_subtractor.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, start 1 cycle -> busy high 8 cycles, done at cycle 9, diff=0x37, borrow=0.
- a=0x23, b=0x5A -> diff=0xC9, borrow=1; the previous diff=0x37 holds throughout SHIFT until done.
- Boundaries:
  - a=0x00, b=0x01 -> diff=0xFF, borrow=1.
  - a=0xFF, b=0xFF -> diff=0x00, borrow=0.
  - a=0x80, b=0x00 -> diff=0x80, borrow=0.
- Start with a=0x10, b=0x01; pulse start again at cycle 3 with a=0xFF, b=0x00 -> second request ignored, done at cycle 9 with diff=0x0F. Then start during the FINISH cycle with a=0x09, b=0x0A -> accepted, next done 9 cycles later with diff=0xFF, borrow=1.
- Assert rst for 1 cycle during SHIFT cycle 4 -> outputs immediately 0, no done pulse. A fresh start with a=0x03, b=0x02 then gives diff=0x01, borrow=0.
- Random regression: 1000 random a/b pairs at WIDTH=8 and WIDTH=16 against a reference model ((a-b) mod 2^W, a<b). Check each done occurs exactly WIDTH+1 cycles after the accepted start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor slice.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Bit counter must hold WIDTH-1 without wrapping
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtractor cells; the full cell chains two half cells like the adder datapath.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);
  assign d    = x ^ y;
  assign bout = ~x & y;
endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .bout(b1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bout(b2));

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             bff;
  logic [CW-1:0]    cnt;
  logic             d, bo;
  logic             accept, last;
  logic             busy_nx, done_nx;

  full_subtractor u_fs (.x(sa[0]), .y(sb[0]), .bin(bff), .d(d), .bout(bo));

  // A start is only honoured when not shifting; FINISH allows back-to-back issue
  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_FINISH));
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nx = ST_SHIFT;
      ST_SHIFT:  if (last) state_nx = ST_FINISH;
      ST_FINISH: state_nx = bus.start ? ST_SHIFT : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Status flags decoded from the next state so they can be registered without lag
  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    case (state_nx)
      ST_SHIFT:  busy_nx = 1'b1;
      ST_FINISH: done_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= busy_nx;
      bus.done <= done_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      bff        <= 1'b0;
      cnt        <= '0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      sr  <= '0;
      bff <= 1'b0;
      cnt <= '0;
    end else if (state == ST_SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {d, sr[WIDTH-1:1]};
      bff <= bo;
      cnt <= cnt + CW'(1);
      // Result is published only on the edge that enters FINISH
      if (last) begin
        bus.diff   <= {d, sr[WIDTH-1:1]};
        bus.borrow <= bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    int unsigned cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      check(q8.size() != 0, "w8_done_expected", 32'(q8.size()), 32'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check(32'(bus8.diff) === e8.diff, "w8_diff", 32'(bus8.diff), e8.diff);
        check(bus8.borrow === e8.borrow, "w8_borrow", 32'(bus8.borrow), 32'(e8.borrow));
        check(cyc == e8.cyc + 9, "w8_latency", cyc - e8.cyc, 32'd9);
      end
    end
    if (bus16.done === 1'b1) begin
      check(q16.size() != 0, "w16_done_expected", 32'(q16.size()), 32'd1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        check(32'(bus16.diff) === e16.diff, "w16_diff", 32'(bus16.diff), e16.diff);
        check(bus16.borrow === e16.borrow, "w16_borrow", 32'(bus16.borrow), 32'(e16.borrow));
        check(cyc == e16.cyc + 17, "w16_latency", cyc - e16.cyc, 32'd17);
      end
    end
  end

  // Called at a negedge in IDLE or FINISH; returns at the FINISH negedge of this op.
  // inject=1 pulses a rejected start with different operands mid-SHIFT.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ediff, input logic eb, input bit inject);
    logic [7:0] prev;
    prev = bus8.diff;
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    q8.push_back('{32'(ediff), eb, cyc});
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 2) begin
        bus8.start = 1'b1;
        bus8.a = 8'hFF;
        bus8.b = 8'h00;
      end
      if (inject && i == 3) bus8.start = 1'b0;
      check(bus8.busy === 1'b1, "w8_busy", 32'(bus8.busy), 32'd1);
      check(bus8.diff === prev, "w8_diff_hold", 32'(bus8.diff), 32'(prev));
      @(negedge clk);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] prev;
    prev = bus16.diff;
    bus16.start = 1'b1;
    bus16.a = a;
    bus16.b = b;
    q16.push_back('{32'(16'(a - b)), (a < b), cyc});
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a = ~a;
    for (int i = 0; i < 16; i++) begin
      check(bus16.busy === 1'b1, "w16_busy", 32'(bus16.busy), 32'd1);
      check(bus16.diff === prev, "w16_diff_hold", 32'(bus16.diff), 32'(prev));
      @(negedge clk);
    end
  endtask

  task automatic seq8();
    logic [7:0] ra, rb;
    op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0); @(negedge clk);
    op8(8'h23, 8'h5A, 8'hC9, 1'b1, 1'b0); @(negedge clk);
    op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0); @(negedge clk);
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0); @(negedge clk);
    op8(8'h80, 8'h00, 8'h80, 1'b0, 1'b0); @(negedge clk);
    op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
    op8(8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0); @(negedge clk);
    // Abandoned operation: nothing queued, so any done pulse is flagged
    bus8.start = 1'b1;
    bus8.a = 8'h77;
    bus8.b = 8'h11;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    #1;
    check(bus8.diff === 8'h00, "w8_rst_diff", 32'(bus8.diff), 32'd0);
    check(bus8.borrow === 1'b0, "w8_rst_borrow", 32'(bus8.borrow), 32'd0);
    check(bus8.busy === 1'b0, "w8_rst_busy", 32'(bus8.busy), 32'd0);
    check(bus8.done === 1'b0, "w8_rst_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    rst8 = 1'b0;
    repeat (2) @(negedge clk);
    op8(8'h03, 8'h02, 8'h01, 1'b0, 1'b0); @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, 8'(ra - rb), (ra < rb), 1'b0);
      if (n % 3 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic seq16();
    op16(16'h1234, 16'h0234);
    op16(16'h0000, 16'h0001); @(negedge clk);
    op16(16'hFFFF, 16'hFFFF); @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      if (n % 2 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    rst8 = 1'b1;
    rst16 = 1'b1;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    repeat (2) @(negedge clk);
    check(bus8.busy === 1'b0, "w8_reset_busy", 32'(bus8.busy), 32'd0);
    check(bus8.done === 1'b0, "w8_reset_done", 32'(bus8.done), 32'd0);
    check(bus8.diff === 8'h00, "w8_reset_diff", 32'(bus8.diff), 32'd0);
    check(bus8.borrow === 1'b0, "w8_reset_borrow", 32'(bus8.borrow), 32'd0);
    check(bus16.diff === 16'h0000, "w16_reset_diff", 32'(bus16.diff), 32'd0);
    rst8 = 1'b0;
    rst16 = 1'b0;
    @(negedge clk);
    fork
      seq8();
      seq16();
    join
    repeat (3) @(negedge clk);
    check(q8.size() == 0, "w8_queue_drained", 32'(q8.size()), 32'd0);
    check(q16.size() == 0, "w16_queue_drained", 32'(q16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    total++;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
